// File: rtl/ysyx_24080014_pkg.sv
// Shared definitions for the write-back sequencer: rd source select codes,
// load width/sign codes and the write-back FSM state encoding.
package ysyx_24080014_pkg;

  // rd source select
  localparam logic [2:0] RD_PC        = 3'b000;
  localparam logic [2:0] RD_PC_ADD    = 3'b001;
  localparam logic [2:0] RD_ALU_OUT   = 3'b010;
  localparam logic [2:0] RD_IMM       = 3'b011;
  localparam logic [2:0] RD_READ_DATA = 3'b100;

  // load width / sign (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_MEM_REQ  = 2'd1,
    WB_MEM_WAIT = 2'd2,
    WB_WRITE    = 2'd3
  } wb_state_e;

endpackage

// File: rtl/ysyx_24080014_wb_ctrl_if.sv
// Bus bundle for the write-back sequencer: EXU handoff, data-memory read
// port and register-file write port.
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is high only while the controller is idle;
// in_valid may be held high while in_ready is low and no transfer happens.
// The memory read port transfers the request on a rising edge with mem_req
// and mem_gnt both 1; data returns on a later edge with mem_rvalid 1.
//
// Modports: slave is the write-back controller, master is its environment
// (EXU, data memory and register file).
interface ysyx_24080014_wb_ctrl_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_rd_ctl;
  logic [4:0]      in_rd;
  logic            in_rf_wen;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_alu_out;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            wb_done;
  logic            wb_err;

  modport slave (
    input  in_valid, in_rd_ctl, in_rd, in_rf_wen, in_funct3, in_pc, in_imm, in_alu_out,
    output in_ready,
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output rf_wen, rf_waddr, rf_wdata, wb_done, wb_err
  );

  modport master (
    output in_valid, in_rd_ctl, in_rd, in_rf_wen, in_funct3, in_pc, in_imm, in_alu_out,
    input  in_ready,
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  rf_wen, rf_waddr, rf_wdata, wb_done, wb_err
  );

endinterface

// File: rtl/ysyx_24080014_load_ext.sv
// Load data extraction: picks the byte/half/word addressed by the low
// address bits from a read word and sign- or zero-extends it.
// Misaligned offsets are not trapped; a halfword uses off[1] only.
module ysyx_24080014_load_ext
  import ysyx_24080014_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by width/sign extension.
  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = '0;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24080014_wb_ctrl.sv
// Write-back sequencer between EXU and register file. Accepts one retiring
// instruction, optionally performs the data-memory read for a load, then
// issues a single register-file write together with a wb_done pulse.
// Optional load timeout: define YSYX_24080014_WB_TIMEOUT_EN.
module ysyx_24080014_wb_ctrl
  import ysyx_24080014_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_24080014_wb_ctrl_if.slave      bus,
  output wb_state_e                   dbg_state_o
);

  wb_state_e       state_q, state_d;
  logic            ready_q;
  logic            accept;
  logic            load_en;
  logic [2:0]      rd_ctl_q;
  logic [4:0]      rd_q;
  logic            rf_wen_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] pc_q, imm_q, alu_q, load_q;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] wdata;

  assign accept = bus.in_valid && ready_q;

  ysyx_24080014_load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata_i  (bus.mem_rdata),
    .off_i    (alu_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_ext)
  );

`ifdef YSYX_24080014_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort;
  logic             err_q;

  // Timeout counter: cleared on accept, advances while a load is pending.
  always_comb begin
    cnt_d = cnt_q;
    abort = 1'b0;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == WB_MEM_REQ || state_q == WB_MEM_WAIT) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) abort = 1'b1;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and abort flag registers; the flag lives until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) err_q <= 1'b0;
      else if (abort) err_q <= 1'b1;
    end
  end
`endif

  // Next-state logic; load data is captured only on a genuine rvalid.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    case (state_q)
      WB_IDLE:     if (accept) state_d = (bus.in_rd_ctl == RD_READ_DATA) ? WB_MEM_REQ : WB_WRITE;
      WB_MEM_REQ:  if (bus.mem_gnt) state_d = WB_MEM_WAIT;
      WB_MEM_WAIT: if (bus.mem_rvalid) begin
                     state_d = WB_WRITE;
                     load_en = 1'b1;
                   end
      WB_WRITE:    state_d = WB_IDLE;
      default:     state_d = WB_IDLE;
    endcase
`ifdef YSYX_24080014_WB_TIMEOUT_EN
    if (abort) begin
      state_d = WB_WRITE;
      load_en = 1'b0;
    end
`endif
  end

  // State register; in_ready is registered so it stays low through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WB_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == WB_IDLE);
    end
  end

  // Instruction fields latched on accept, load result latched on rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ctl_q <= RD_PC;
      rd_q     <= '0;
      rf_wen_q <= 1'b0;
      funct3_q <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      alu_q    <= '0;
      load_q   <= '0;
    end else begin
      if (accept) begin
        rd_ctl_q <= bus.in_rd_ctl;
        rd_q     <= bus.in_rd;
        rf_wen_q <= bus.in_rf_wen;
        funct3_q <= bus.in_funct3;
        pc_q     <= bus.in_pc;
        imm_q    <= bus.in_imm;
        alu_q    <= bus.in_alu_out;
      end
      if (load_en) load_q <= load_ext;
    end
  end

  // rd write-data source select from latched fields only.
  always_comb begin
    wdata = '0;
    case (rd_ctl_q)
      RD_PC:        wdata = pc_q;
      RD_PC_ADD:    wdata = pc_q + XLEN'(4);
      RD_ALU_OUT:   wdata = alu_q;
      RD_IMM:       wdata = imm_q;
      RD_READ_DATA: wdata = load_q;
      default:      wdata = '0;
    endcase
  end

  assign bus.in_ready = ready_q;
  assign bus.mem_req  = (state_q == WB_MEM_REQ);
  assign bus.mem_addr = {alu_q[XLEN-1:2], 2'b00};
  assign bus.rf_waddr = rd_q;
  assign bus.rf_wdata = wdata;
  assign bus.wb_done  = (state_q == WB_WRITE);
`ifdef YSYX_24080014_WB_TIMEOUT_EN
  assign bus.rf_wen   = (state_q == WB_WRITE) && rf_wen_q && (rd_q != 5'd0) && !err_q;
  assign bus.wb_err   = (state_q == WB_WRITE) && err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign bus.rf_wen   = (state_q == WB_WRITE) && rf_wen_q && (rd_q != 5'd0);
  assign bus.wb_err   = 1'b0;
`endif
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ysyx_24080014_wb_ctrl.sv
// Directed bench for the write-back sequencer: non-load sources, load
// extraction with delayed grant, rd=x0 suppression, reset mid-load and
// an indefinitely stalled load in the default build.
module tb_ysyx_24080014_wb_ctrl;
  import ysyx_24080014_pkg::*;

  logic      clk;
  logic      rst;
  wb_state_e dbg_state;

  ysyx_24080014_wb_ctrl_if #(.XLEN(32)) bus();

  ysyx_24080014_wb_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int          n_checks;
  int          n_pass;
  logic [31:0] exp_q[$];

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp_v);
  endtask

  // Driver tasks
  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_rd_ctl  = 3'b000;
    bus.in_rd      = 5'd0;
    bus.in_rf_wen  = 1'b0;
    bus.in_funct3  = 3'b000;
    bus.in_pc      = '0;
    bus.in_imm     = '0;
    bus.in_alu_out = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic send(input logic [2:0] ctl, input logic [4:0] rd, input logic wen,
                      input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] alu);
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid   = 1'b1;
    bus.in_rd_ctl  = ctl;
    bus.in_rd      = rd;
    bus.in_rf_wen  = wen;
    bus.in_funct3  = f3;
    bus.in_pc      = pc;
    bus.in_imm     = imm;
    bus.in_alu_out = alu;
  endtask

  // Scoreboard side of a write cycle.
  task automatic check_write(input logic [4:0] rd, input logic exp_wen);
    logic [31:0] e;
    check("wb_done", bus.wb_done, 1);
    check("rf_wen", bus.rf_wen, exp_wen);
    check("wb_err", bus.wb_err, 0);
    check("rf_waddr", bus.rf_waddr, rd);
    check("sb_pending", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rf_wdata", bus.rf_wdata, e);
    end
  endtask

  task automatic run_alu(input logic [2:0] ctl, input logic [4:0] rd, input logic wen,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                         input logic [31:0] exp_data, input logic exp_wen);
    exp_q.push_back(exp_data);
    send(ctl, rd, wen, 3'b000, pc, imm, alu);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_write(rd, exp_wen);
    @(negedge clk);
    check("done_pulse", bus.wb_done, 0);
    check("ready_back", bus.in_ready, 1);
  endtask

  // in_valid stays high throughout; stray rvalid is driven while waiting for gnt.
  task automatic run_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] rdata, input int gnt_delay,
                          input logic [31:0] exp_data, input logic exp_wen);
    logic [31:0] addr;
    addr = {alu[31:2], 2'b00};
    exp_q.push_back(exp_data);
    send(RD_READ_DATA, rd, 1'b1, f3, 32'h0, 32'h0, alu);
    for (int i = 0; i < gnt_delay; i++) begin
      @(negedge clk);
      check("mem_req_wait", bus.mem_req, 1);
      check("mem_addr", bus.mem_addr, addr);
      check("ready_busy", bus.in_ready, 0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5A5A_5A5A;
    end
    @(negedge clk);
    check("mem_req", bus.mem_req, 1);
    check("mem_addr", bus.mem_addr, addr);
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b1;
    @(negedge clk);
    check("mem_req_low", bus.mem_req, 0);
    check("state_wait", dbg_state, WB_MEM_WAIT);
    check("ready_busy", bus.in_ready, 0);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.in_valid   = 1'b0;
    check_write(rd, exp_wen);
    @(negedge clk);
    check("done_pulse", bus.wb_done, 0);
    check("ready_back", bus.in_ready, 1);
  endtask

  // Main sequence and final report
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_rf_wen", bus.rf_wen, 0);
    check("rst_wb_done", bus.wb_done, 0);
    check("rst_wb_err", bus.wb_err, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_rf_waddr", bus.rf_waddr, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    check("rst_state", dbg_state, WB_IDLE);
    rst = 1'b0;

    // Non-load sources
    run_alu(RD_PC_ADD,  5'd5,  1'b1, 32'h8000_0000, 32'h0, 32'h0, 32'h8000_0004, 1'b1);
    run_alu(RD_PC_ADD,  5'd6,  1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0000_0000, 1'b1);
    run_alu(RD_PC,      5'd1,  1'b1, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678, 1'b1);
    run_alu(RD_IMM,     5'd31, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b1);
    run_alu(RD_ALU_OUT, 5'd0,  1'b1, 32'h0, 32'h0, 32'h0000_1234, 32'h0000_1234, 1'b0);
    run_alu(RD_ALU_OUT, 5'd7,  1'b0, 32'h0, 32'h0, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0);
    run_alu(3'b101,     5'd3,  1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0, 1'b1);

    // Loads
    run_load(F3_LB,  5'd10, 32'h8000_1003, 32'h80AA_BBCC, 2, 32'hFFFF_FF80, 1'b1);
    run_load(F3_LBU, 5'd11, 32'h8000_1003, 32'h80AA_BBCC, 0, 32'h0000_0080, 1'b1);
    run_load(F3_LHU, 5'd12, 32'h8000_1002, 32'hBEEF_1234, 1, 32'h0000_BEEF, 1'b1);
    run_load(F3_LH,  5'd13, 32'h8000_1000, 32'h0000_8001, 0, 32'hFFFF_8001, 1'b1);
    run_load(F3_LW,  5'd14, 32'h8000_1001, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b1);
    run_load(F3_LH,  5'd15, 32'h0000_0003, 32'h7FFF_0000, 0, 32'h0000_7FFF, 1'b1);
    run_load(F3_LB,  5'd16, 32'h0000_0001, 32'h0000_7F00, 0, 32'h0000_007F, 1'b1);
    run_load(3'b011, 5'd17, 32'h0000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1'b1);
    run_load(F3_LW,  5'd0,  32'h0000_0010, 32'h1234_5678, 0, 32'h1234_5678, 1'b0);

    // Reset while waiting for read data abandons the load
    send(RD_READ_DATA, 5'd20, 1'b1, F3_LW, 32'h0, 32'h0, 32'h0000_0100);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mem_gnt  = 1'b1;
    @(negedge clk);
    check("rst_test_wait", dbg_state, WB_MEM_WAIT);
    bus.mem_gnt = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    check("midrst_ready", bus.in_ready, 0);
    check("midrst_state", dbg_state, WB_IDLE);
    check("midrst_mem_req", bus.mem_req, 0);
    check("midrst_wb_done", bus.wb_done, 0);
    check("midrst_mem_addr", bus.mem_addr, 0);
    rst            = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_1111;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("postrst_ready", bus.in_ready, 1);
    check("postrst_rf_wen", bus.rf_wen, 0);
    check("postrst_wb_done", bus.wb_done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_quiet", {bus.wb_done, bus.rf_wen}, 0);
    end

    // Default build: a load with no grant waits indefinitely, then completes
    run_load(F3_LW, 5'd9, 32'h0000_0040, 32'h1357_9BDF, 1000, 32'h1357_9BDF, 1'b1);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
